// File: rtl/dmem_access_ctrl_if.sv
// Bundle between dmem_access_ctrl and its CPU, debug and memory neighbours.
// slave is the controller's view, master the environment's view.
`timescale 1ns/1ps
interface dmem_access_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        dbg_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack, dbg_err,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack, dbg_err,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Round-robin CPU/debug arbiter and load/store sequencer for a word-wide
// data memory; sub-word stores go through a read-modify-write.
`timescale 1ns/1ps
module dmem_access_ctrl #(
  parameter int WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave bus,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        own_q;
  logic        err_q;
  logic        last_gnt;

  logic        gnt;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [2:0]  g_size;
  logic        g_we;
  logic        g_err;
  logic        word_op;
  logic        wr_en;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  function automatic logic bad_req(
    logic        we,
    logic [2:0]  sz,
    logic [31:0] a
  );
    logic ill;
    logic mis;
    logic oor;
    ill = (sz == 3'b011) || (sz[2:1] == 2'b11)
       || (we && sz[2]);
    mis = ((sz[1:0] == 2'b01) && a[0])
       || ((sz[1:0] == 2'b10) && (a[1:0] != 2'b00));
    oor = a[31:2] >= 30'(WORDS);
    return ill || mis || oor;
  endfunction

  // on a tie the port that did not win last time goes first
  assign gnt = (bus.cpu_req && bus.dbg_req)
             ? ~last_gnt : bus.dbg_req;

  assign g_addr  = gnt ? bus.dbg_addr  : bus.cpu_addr;
  assign g_wdata = gnt ? bus.dbg_wdata : bus.cpu_wdata;
  assign g_we    = gnt ? bus.dbg_we    : bus.cpu_we;
  assign g_size  = gnt ? 3'b010        : bus.cpu_size;
  assign g_err   = bad_req(g_we, g_size, g_addr);

  assign word_op = size_q[1:0] == 2'b10;

  always_comb begin
    rd_b   = 8'(bus.mem_read_data >> {addr_q[1:0], 3'b000});
    rd_h   = 16'(bus.mem_read_data >> {addr_q[1], 4'b0000});
    ld_val = bus.mem_read_data;
    unique case (1'b1)
      size_q[1:0] == 2'b00:
        ld_val = {{24{rd_b[7] & ~size_q[2]}}, rd_b};
      size_q[1:0] == 2'b01:
        ld_val = {{16{rd_h[15] & ~size_q[2]}}, rd_h};
      default: ;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign wr_en = (state == MERGE)
              || (state == ACCESS && we_q && word_op);

  assign busy                 = state != IDLE;
  assign bus.mem_address      = {addr_q[31:2], 2'b00};
  assign bus.mem_write_enable = wr_en;
  assign bus.mem_write_data   = (state == MERGE) ? merged
                              : (wr_en ? wdata_q : '0);

  assign bus.cpu_ack   = (state == RESP) && (own_q == CPU);
  assign bus.dbg_ack   = (state == RESP) && (own_q == DBG);
  assign bus.cpu_rdata = rdata_q;
  assign bus.dbg_rdata = rdata_q;
  assign bus.cpu_err   = err_q;
  assign bus.dbg_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      own_q    <= CPU;
      err_q    <= 1'b0;
      last_gnt <= DBG;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dbg_req) begin
            addr_q   <= g_addr;
            wdata_q  <= g_wdata;
            size_q   <= g_size;
            we_q     <= g_we;
            own_q    <= gnt;
            last_gnt <= gnt;
            err_q    <= g_err;
            state    <= g_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= ld_val;
            state   <= RESP;
          end else if (word_op) begin
            state <= RESP;
          end else begin
            merge_q <= bus.mem_read_data;
            state   <= MERGE;
          end
        end
        MERGE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vectors against a shadow-memory
// model, with a per-cycle compare of acks, write pulses and busy.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
  localparam int WORDS = 64;

  typedef struct {
    logic        own;
    logic        err;
    logic        ld;
    logic [31:0] rd;
    int          acc;
    int          ack;
  } exp_t;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_idle = 0;

  exp_t        eq[$];
  wr_t         wq[$];
  logic [31:0] mem [WORDS];
  logic [31:0] mm  [WORDS];

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // data memory: combinational read, word 0 write-protected
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];
  always @(posedge clk)
    if (bus.mem_write_enable && bus.mem_address[7:2] != 6'd0)
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_note(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event absent, event required (cycle %0d)",
             nm, cyc);
  endtask

  task automatic model_push(input logic own, input logic we,
                            input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int pres,
                            input bit commit);
    exp_t            e;
    wr_t             w;
    int              nb;
    int              sh;
    int              idx;
    int              lat;
    bit              legal;
    longint unsigned mask;
    longint unsigned word;
    longint unsigned v;
    case (sz)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we;
      default:                legal = 1'b0;
    endcase
    nb = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    e.err = !legal || (a % 32'(nb) != 0) || (a / 4 >= 32'(WORDS));
    lat = e.err ? 1 : (we && nb < 4) ? 3 : 2;
    e.own = own;
    e.ld  = !we;
    e.acc = (pres > next_idle) ? pres : next_idle;
    e.ack = e.acc + lat;
    next_idle = e.ack + 1;
    e.rd = '0;
    if (!e.err) begin
      idx  = int'(a / 4);
      sh   = 8 * int'(a % 4);
      mask = (64'd1 << (8 * nb)) - 1;
      word = 64'(mm[idx]);
      if (!we) begin
        v = (word >> sh) & mask;
        if (!sz[2] && v > mask / 2) v = v + 64'hFFFF_FFFF - mask;
        e.rd = v[31:0];
      end else begin
        v = (word & ~(mask << sh)) | ((64'(wd) & mask) << sh);
        w.c = e.acc + ((nb < 4) ? 2 : 1);
        w.a = a & 32'hFFFF_FFFC;
        w.d = v[31:0];
        if (commit) begin
          wq.push_back(w);
          if (idx != 0) mm[idx] = v[31:0];
        end
      end
    end
    eq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    logic bexp;
    logic wexp;
    logic ack_any;
    if (rst_n) begin
      bexp = eq.size() > 0 && cyc > eq[0].acc && cyc <= eq[0].ack;
      chk("busy", 32'(busy), 32'(bexp));
      wexp = wq.size() > 0 && wq[0].c == cyc;
      chk("wr_en", 32'(bus.mem_write_enable), 32'(wexp));
      if (wexp) begin
        w = wq.pop_front();
        chk("wr_addr", bus.mem_address, w.a);
        chk("wr_data", bus.mem_write_data, w.d);
      end
      while (wq.size() > 0 && wq[0].c < cyc) void'(wq.pop_front());
      ack_any = bus.cpu_ack || bus.dbg_ack;
      if (ack_any) begin
        chk("dual_ack", 32'(bus.cpu_ack && bus.dbg_ack), 32'd0);
        if (eq.size() == 0) begin
          fail_note("unexpected_ack_has_no_request");
        end else begin
          e = eq.pop_front();
          chk("ack_owner", 32'(bus.dbg_ack), 32'(e.own));
          chk("ack_cycle", 32'(cyc), 32'(e.ack));
          chk("ack_err", 32'(bus.dbg_ack ? bus.dbg_err : bus.cpu_err),
              32'(e.err));
          if (e.ld && !e.err)
            chk("ack_rdata",
                bus.dbg_ack ? bus.dbg_rdata : bus.cpu_rdata, e.rd);
        end
      end else if (eq.size() > 0 && cyc >= eq[0].ack) begin
        fail_note("ack_missing");
        void'(eq.pop_front());
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 32'd0);
    chk({tag, "_dbg_ack"}, 32'(bus.dbg_ack), 32'd0);
    chk({tag, "_cpu_rd"}, bus.cpu_rdata, 32'd0);
    chk({tag, "_dbg_rd"}, bus.dbg_rdata, 32'd0);
    chk({tag, "_cpu_err"}, 32'(bus.cpu_err), 32'd0);
    chk({tag, "_dbg_err"}, 32'(bus.dbg_err), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_write_enable), 32'd0);
    chk({tag, "_maddr"}, bus.mem_address, 32'd0);
    chk({tag, "_mdata"}, bus.mem_write_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic cpu_op(input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic lerr, input bit lit_en,
                        input logic [31:0] lit);
    int n;
    model_push(1'b0, we, sz, a, wd, cyc, 1'b1);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_size  = sz;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 10);
    if (!bus.cpu_ack) begin
      fail_note("cpu_ack_timeout");
    end else begin
      chk("cpu_err_lit", 32'(bus.cpu_err), 32'(lerr));
      if (lit_en) chk("cpu_rd_lit", bus.cpu_rdata, lit);
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic lerr,
                        input bit lit_en, input logic [31:0] lit);
    int n;
    model_push(1'b1, we, 3'b010, a, wd, cyc, 1'b1);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dbg_ack && n < 10);
    if (!bus.dbg_ack) begin
      fail_note("dbg_ack_timeout");
    end else begin
      chk("dbg_err_lit", 32'(bus.dbg_err), 32'(lerr));
      if (lit_en) chk("dbg_rd_lit", bus.dbg_rdata, lit);
    end
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active, completion required");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int n_ack;
    int n_c;
    int n_d;
    logic first_own;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] <= '0;
      mm[i] = '0;
    end
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_size  = 3'b000;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("rst");
    rst_n = 1'b1;
    next_idle = cyc;

    cpu_op(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    cpu_op(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
    dbg_op(1, 32'h20, 32'h11223344, 0, 0, 0);
    cpu_op(1, 3'b000, 32'h21, 32'h123456AA, 0, 0, 0);
    chk("rmw_sb_word", mem[8], 32'h1122AA44);
    cpu_op(0, 3'b000, 32'h21, 32'h0, 0, 1, 32'hFFFFFFAA);
    cpu_op(0, 3'b100, 32'h21, 32'h0, 0, 1, 32'h000000AA);
    cpu_op(1, 3'b001, 32'h22, 32'hFFFF8001, 0, 0, 0);
    chk("rmw_sh_word", mem[8], 32'h8001AA44);
    cpu_op(0, 3'b001, 32'h22, 32'h0, 0, 1, 32'hFFFF8001);
    cpu_op(0, 3'b101, 32'h22, 32'h0, 0, 1, 32'h00008001);
    cpu_op(0, 3'b000, 32'h23, 32'h0, 0, 1, 32'hFFFFFF80);
    cpu_op(0, 3'b001, 32'h20, 32'h0, 0, 1, 32'hFFFFAA44);
    cpu_op(0, 3'b100, 32'h20, 32'h0, 0, 1, 32'h00000044);

    cpu_op(0, 3'b010, 32'h13, 32'h0, 1, 0, 0);
    cpu_op(0, 3'b001, 32'h21, 32'h0, 1, 0, 0);
    cpu_op(1, 3'b010, 32'h100, 32'h1, 1, 0, 0);
    cpu_op(0, 3'b011, 32'h10, 32'h0, 1, 0, 0);
    cpu_op(0, 3'b010, 32'h100, 32'h0, 1, 0, 0);
    cpu_op(1, 3'b100, 32'h10, 32'h77, 1, 0, 0);
    cpu_op(0, 3'b110, 32'h10, 32'h0, 1, 0, 0);
    cpu_op(1, 3'b000, 32'hFFFF_FFF0, 32'h1, 1, 0, 0);
    dbg_op(0, 32'h12, 32'h0, 1, 0, 0);
    dbg_op(0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
    chk("err_no_write", mem[4], 32'hDEADBEEF);

    dbg_op(1, 32'hFC, 32'hCAFEF00D, 0, 0, 0);
    cpu_op(0, 3'b010, 32'hFC, 32'h0, 0, 1, 32'hCAFEF00D);
    cpu_op(1, 3'b010, 32'h0, 32'h5, 0, 0, 0);
    cpu_op(0, 3'b010, 32'h0, 32'h0, 0, 1, 32'h00000000);

    // sub-word store cut short by reset while in MERGE
    model_push(1'b0, 1'b1, 3'b000, 32'h10, 32'h55, cyc, 1'b0);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_size  = 3'b000;
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("merge_we_high", 32'(bus.mem_write_enable), 32'd1);
    chk("merge_busy_high", 32'(busy), 32'd1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk_quiet("midrst");
    eq.delete();
    wq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_idle = cyc;
    chk("midrst_word_kept", mem[4], 32'hDEADBEEF);

    // both ports held from reset: grants must alternate CPU first
    model_push(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, cyc, 1'b1);
    model_push(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, cyc, 1'b1);
    model_push(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, cyc, 1'b1);
    model_push(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, cyc, 1'b1);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_size  = 3'b010;
    bus.cpu_addr  = 32'h10;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'h20;
    n = 0;
    n_ack = 0;
    n_c = 0;
    n_d = 0;
    first_own = 1'bx;
    while (n_ack < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack || bus.dbg_ack) begin
        if (n_ack == 0) first_own = bus.dbg_ack;
        n_ack++;
        if (bus.cpu_ack) n_c++;
        if (bus.dbg_ack) n_d++;
      end
    end
    if (n_ack < 4) fail_note("arb_ack_timeout");
    chk("arb_first_cpu", 32'(first_own), 32'd0);
    chk("arb_cpu_acks", 32'(n_c), 32'd2);
    chk("arb_dbg_acks", 32'(n_d), 32'd2);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;

    cpu_op(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    #1;
    chk("eq_drained", 32'(eq.size()), 32'd0);
    for (int i = 0; i < WORDS; i++)
      chk("mem_final", mem[i], mm[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
